// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: transmitter, synchronized receiver, receive FIFO,
// status/control registers, and a receive interrupt for the core's trap logic.
module uart_mmio #(
  parameter int          CLKS_PER_BIT  = 868,
  parameter int          RX_FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        uart_IRQ,
  input  logic        rx,
  output logic        tx
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(RX_FIFO_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [1:0] off;
  logic       wr;
  logic       rd;
  logic       unused_bits;

  assign sel = (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_en != 4'h0);
  assign off = mem_addr[3:2];
  assign wr  = sel && mem_wea;
  assign rd  = sel && mem_rea;
  assign unused_bits = ^{mem_addr[1:0], mem_din[31:8]};

  // ---------------------------------------------------------------- TX
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_q;
  logic          tx_last;
  logic          tx_busy;
  logic          tx_accept;

  assign tx_last = (tx_cnt == BIT_LAST);
  // Busy drops in the final stop-bit cycle so a held store is taken there and
  // the next start bit follows the stop bit with no idle gap.
  assign tx_busy   = (tx_state != TX_IDLE) && !((tx_state == TX_STOP) && tx_last);
  assign tx_accept = wr && (off == 2'd0) && !tx_busy;
  assign mem_hold  = !Rst && wr && (off == 2'd0) && tx_busy;
  assign tx        = tx_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
    end else if (tx_accept) begin
      tx_state <= TX_START;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= mem_din[7:0];
      tx_q     <= 1'b0;
    end else begin
      case (tx_state)
        TX_START: begin
          if (tx_last) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_q     <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_q     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_q     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic          rx_fall;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_last;
  logic          rx_stop_sample;

  assign rx_fall        = rx_prev && !rx_s2;
  assign rx_last        = (rx_cnt == BIT_LAST);
  assign rx_stop_sample = (rx_state == RX_STOP) && rx_last;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_last) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
              rx_bit   <= '0;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_last) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          rx_empty;
  logic          rx_full;
  logic          rx_pop;
  logic          rx_push;
  logic          overrun_set;
  logic          frame_set;

  assign rx_empty    = (count == '0);
  assign rx_full     = (count == FULL_CNT);
  assign rx_pop      = rd && (off == 2'd1) && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign rx_push     = rx_stop_sample && rx_s2 && (!rx_full || rx_pop);
  assign overrun_set = rx_stop_sample && rx_s2 && rx_full && !rx_pop;
  assign frame_set   = rx_stop_sample && !rx_s2;

  always_ff @(posedge clk) begin
    if (!Rst && rx_push) fifo_mem[wptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (rx_push) wptr <= wptr + 1'b1;
      if (rx_pop)  rptr <= rptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  logic        overrun;
  logic        frame_err;
  logic        rx_irq_en;
  logic [31:0] status;
  logic [31:0] rdata;

  assign status = {27'b0, frame_err, overrun, rx_full, rx_empty, tx_busy};

  always_ff @(posedge clk) begin
    if (Rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq_en <= 1'b0;
    end else begin
      if (wr && (off == 2'd2)) begin
        if (mem_din[3]) overrun   <= 1'b0;
        if (mem_din[4]) frame_err <= 1'b0;
      end
      if (overrun_set) overrun   <= 1'b1;
      if (frame_set)   frame_err <= 1'b1;
      if (wr && (off == 2'd3)) rx_irq_en <= mem_din[0];
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      2'd1:    rdata = rx_empty ? 32'h8000_0000 : {24'b0, fifo_mem[rptr]};
      2'd2:    rdata = status;
      2'd3:    rdata = {31'b0, rx_irq_en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      mem_dout <= '0;
      uart_IRQ <= 1'b0;
    end else begin
      mem_dout <= rd ? rdata : '0;
      uart_IRQ <= rx_irq_en && !rx_empty;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: reads and TX frames queue expected values,
// independent monitors compare them against mem_dout and the tx line.
module tb_uart_mmio;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_din = '0;
  logic        mem_wea = 1'b0;
  logic        mem_rea = 1'b0;
  logic [3:0]  mem_en = '0;
  logic [31:0] mem_dout;
  logic        mem_hold;
  logic        uart_IRQ;
  logic        rx = 1'b1;
  logic        tx;

  uart_mmio #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(8), .BASE_ADDR(32'h0000_8000)) dut (
    .clk(clk), .Rst(Rst), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_en(mem_en),
    .mem_dout(mem_dout), .mem_hold(mem_hold), .uart_IRQ(uart_IRQ),
    .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [7:0]  exp_tx_q[$];
  int unsigned tx_start_q[$];
  logic        rd_seen = 1'b0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Read-data monitor
  always @(posedge clk)
    rd_seen <= !Rst && mem_rea && (mem_addr[31:4] == 28'h0000800) && (mem_en != 4'h0);

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got %h with no expected value", mem_dout);
      end else begin
        check(rd_name_q.pop_front(), mem_dout, exp_rd_q.pop_front());
      end
    end else begin
      check("dout_idle", mem_dout, 32'h0);
    end
  end

  // TX frame monitor: samples every cycle of the frame
  initial begin : tx_mon
    logic [9:0]  got;
    logic        stable;
    logic        aborted;
    logic [7:0]  e;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (!Rst && tx === 1'b0) begin
        t0 = cyc; got = '0; stable = 1'b1; aborted = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (Rst) begin aborted = 1'b1; break; end
          if (i % CPB == 0) got[i / CPB] = tx;
          else if (tx !== got[i / CPB]) stable = 1'b0;
        end
        if (aborted) begin
          if (exp_tx_q.size() > 0) void'(exp_tx_q.pop_front());
        end else if (exp_tx_q.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got frame %b with no expected byte", got);
        end else begin
          e = exp_tx_q.pop_front();
          tx_start_q.push_back(t0);
          check("tx_frame", {22'b0, stable, got}, {22'b0, 1'b1, 1'b1, e, 1'b0});
        end
      end
    end
  end

  task automatic bus_read(input logic [31:0] a, input logic [3:0] en,
                          input logic [31:0] e, input string n);
    @(negedge clk);
    mem_addr = a; mem_en = en; mem_rea = 1'b1;
    if (a[31:4] == 28'h0000800 && en != 4'h0) begin
      exp_rd_q.push_back(e);
      rd_name_q.push_back(n);
    end
    @(negedge clk);
    mem_rea = 1'b0; mem_en = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int hc);
    @(negedge clk);
    mem_addr = a; mem_din = d; mem_wea = 1'b1; mem_en = 4'hF; hc = 0;
    #1;
    while (mem_hold && hc < 2000) begin
      @(negedge clk); #1; hc++;
    end
    if (hc >= 2000) begin
      checks++;
      $display("FAIL write_timeout: hold still %b after %0d cycles, required 0", mem_hold, hc);
    end
    @(negedge clk);
    mem_wea = 1'b0; mem_en = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hc;
    int unsigned s0;
    int unsigned s1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_hold", {31'b0, mem_hold}, 32'd0);
    check("rst_irq", {31'b0, uart_IRQ}, 32'd0);
    Rst = 1'b0;

    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_reset");
    bus_read(32'h800C, 4'hF, 32'h0000_0000, "ctrl_reset");
    bus_read(32'h8000, 4'hF, 32'h0000_0000, "txdata_read");
    bus_read(32'h9008, 4'hF, 32'h0, "unselected_addr");
    bus_read(32'h8008, 4'h0, 32'h0, "no_byte_enable");

    // single TX frame
    exp_tx_q.push_back(8'hA5);
    bus_write(32'h8000, 32'hA5, hc);
    check("tx1_hold_cycles", hc, 0);
    bus_read(32'h8008, 4'hF, 32'h0000_0003, "status_tx_busy");
    repeat (45) @(negedge clk);
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_tx_done");

    // back-to-back TX with held store
    tx_start_q.delete();
    exp_tx_q.push_back(8'h11);
    exp_tx_q.push_back(8'h22);
    bus_write(32'h8000, 32'h11, hc);
    check("tx2_first_hold", hc, 0);
    bus_write(32'h8000, 32'h22, hc);
    check("tx2_hold_cycles", hc, 38);
    repeat (45) @(negedge clk);
    check("tx2_frame_count", tx_start_q.size(), 2);
    if (tx_start_q.size() >= 2) begin
      s0 = tx_start_q.pop_front();
      s1 = tx_start_q.pop_front();
      check("tx2_spacing", s1 - s0, 40);
    end

    // RX + interrupt timing
    bus_write(32'h800C, 32'h1, hc);
    send_rx(8'h3C, 1'b1);
    @(negedge clk);
    check("irq_before_push", {31'b0, uart_IRQ}, 32'd0);
    @(negedge clk);
    check("irq_after_push", {31'b0, uart_IRQ}, 32'd1);
    bus_read(32'h8004, 4'hF, 32'h0000_003C, "rx_3c");
    check("irq_pop_cycle", {31'b0, uart_IRQ}, 32'd1);
    @(negedge clk);
    check("irq_cleared", {31'b0, uart_IRQ}, 32'd0);
    bus_read(32'h8004, 4'hF, 32'h8000_0000, "rx_empty_read");

    // fill FIFO and overrun
    for (int i = 0; i < 9; i++) begin
      send_rx(8'h10 + 8'(i), 1'b1);
      repeat (2) @(negedge clk);
    end
    bus_read(32'h8008, 4'hF, 32'h0000_000C, "status_full_overrun");
    check("irq_full", {31'b0, uart_IRQ}, 32'd1);
    bus_write(32'h8008, 32'h8, hc);
    bus_read(32'h8008, 4'hF, 32'h0000_0004, "status_overrun_clr");
    for (int i = 0; i < 8; i++)
      bus_read(32'h8004, 4'hF, 32'h10 + i, "rx_fifo_order");
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_drained");

    // framing error, then glitch
    send_rx(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(32'h8008, 4'hF, 32'h0000_0012, "status_frame_err");
    bus_read(32'h8004, 4'hF, 32'h8000_0000, "rx_after_frame_err");
    bus_write(32'h8008, 32'h10, hc);
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_frame_clr");
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_glitch");
    bus_read(32'h8004, 4'hF, 32'h8000_0000, "rx_after_glitch");

    // reset mid-TX and mid-RX
    exp_tx_q.push_back(8'h5A);
    bus_write(32'h8000, 32'h5A, hc);
    @(negedge clk); rx = 1'b0;
    repeat (11) @(negedge clk);
    Rst = 1'b1; rx = 1'b1;
    mem_addr = 32'h8000; mem_din = 32'hFF; mem_wea = 1'b1; mem_en = 4'hF;
    #1;
    check("hold_in_reset", {31'b0, mem_hold}, 32'd0);
    @(negedge clk);
    mem_wea = 1'b0; mem_en = '0;
    check("tx_after_reset", {31'b0, tx}, 32'd1);
    check("irq_after_reset", {31'b0, uart_IRQ}, 32'd0);
    @(negedge clk);
    Rst = 1'b0;
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_after_reset");
    bus_read(32'h800C, 4'hF, 32'h0000_0000, "ctrl_after_reset");
    send_rx(8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(32'h8004, 4'hF, 32'h0000_00C3, "rx_after_reset");
    bus_read(32'h8008, 4'hF, 32'h0000_0002, "status_final");

    repeat (5) @(negedge clk);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("tx_queue_drained", exp_tx_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
